apb4_regbank: RTL and testbench

Parametrised APB4 completer register bank with byte strobes, programmable wait states, error signalling and per-register access pulses. It is the next-generation replacement for the fixed APB slave register file. It sits on a peripheral APB segment and exposes RW_NUM software-writable control words and RO_NUM hardware-driven status words to the surrounding logic.

---
 rtl/apb4_regbank.sv | 127 ++++++++++++
 tb/tb_apb4_regbank.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/apb4_regbank.sv
// APB4 completer register bank: RW control words, RO status words, wait states.
// Optional macro APB_REGBANK_PPROT_EN rejects unprivileged writes to RW words.
module apb4_regbank #(
    parameter int DW     = 32,
    parameter int AW     = 12,
    parameter int RW_NUM = 8,
    parameter int RO_NUM = 4,
    parameter int WAIT   = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic [AW-1:0]        PADDR,
    input  logic                 PWRITE,
    input  logic [DW-1:0]        PWDATA,
    input  logic [DW/8-1:0]      PSTRB,
    input  logic [2:0]           PPROT,
    output logic [DW-1:0]        PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic [RW_NUM*DW-1:0] reg_dout,
    input  logic [RO_NUM*DW-1:0] reg_din,
    output logic [RW_NUM-1:0]    wr_pulse,
    output logic [RO_NUM-1:0]    rd_pulse
);
    localparam int SW = DW / 8;
    localparam int IW = AW - 2;
    localparam logic [IW-1:0] N_RW  = IW'(RW_NUM);
    localparam logic [IW-1:0] N_ALL = IW'(RW_NUM + RO_NUM);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [IW-1:0]       idx_q;
    logic                wr_q;
    logic                err_q;
    logic [DW-1:0]       rdata_q;
    logic [RW_NUM*DW-1:0] regs_q;

    logic [IW-1:0] idx;
    logic          err_d;
    logic [DW-1:0] rdata_d;
    logic          setup;
    logic          done;
    logic          unused;

    assign idx    = PADDR[AW-1:2];
    assign setup  = (state == IDLE) && PSEL && !PENABLE;
    assign done   = (state == ACCESS) && PSEL && (cnt == 4'd0);
    assign unused = ^{PPROT, PADDR[1:0]};

    always_comb begin
        rdata_d = '0;
        for (int j = 0; j < RW_NUM; j++)
            if (idx == IW'(j)) rdata_d = regs_q[j*DW +: DW];
        for (int k = 0; k < RO_NUM; k++)
            if (idx == IW'(RW_NUM + k)) rdata_d = reg_din[k*DW +: DW];
    end

    always_comb begin
        err_d = (idx >= N_ALL) || (PWRITE && (idx >= N_RW));
`ifdef APB_REGBANK_PPROT_EN
        if (PWRITE && (idx < N_RW) && !PPROT[0]) err_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: if (setup) begin
                    state   <= ACCESS;
                    cnt     <= 4'(WAIT);
                    idx_q   <= idx;
                    wr_q    <= PWRITE;
                    err_q   <= err_d;
                    rdata_q <= rdata_d;
                end
                ACCESS: begin
                    if (!PSEL)               state <= IDLE;
                    else if (cnt != 4'd0)    cnt   <= cnt - 4'd1;
                    else                     state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write data and strobes are taken from the bus at the completion edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            regs_q   <= '0;
            wr_pulse <= '0;
            rd_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            rd_pulse <= '0;
            if (done && !err_q) begin
                for (int j = 0; j < RW_NUM; j++) begin
                    if (wr_q && (idx_q == IW'(j))) begin
                        wr_pulse[j] <= 1'b1;
                        for (int b = 0; b < SW; b++)
                            if (PSTRB[b])
                                regs_q[j*DW+b*8 +: 8] <= PWDATA[b*8 +: 8];
                    end
                end
                for (int k = 0; k < RO_NUM; k++)
                    if (!wr_q && (idx_q == IW'(RW_NUM + k)))
                        rd_pulse[k] <= 1'b1;
            end
        end
    end

    assign PREADY   = (state == ACCESS) && (cnt == 4'd0);
    assign PSLVERR  = PREADY && err_q;
    assign PRDATA   = (PREADY && !err_q && !wr_q) ? rdata_q : '0;
    assign reg_dout = regs_q;

endmodule

// File: tb/tb_apb4_regbank.sv
// Bench for apb4_regbank: three instances with WAIT = 0, 2 and 3 on a shared bus.
// Table-driven vectors plus hand-written abort, reset and PPROT sequences.
module tb_apb4_regbank;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [2:0] sel = '0;
    logic PENABLE = 1'b0;
    logic [11:0] PADDR = '0;
    logic PWRITE = 1'b0;
    logic [31:0] PWDATA = '0;
    logic [3:0] PSTRB = '0;
    logic [2:0] PPROT = 3'b001;
    logic [127:0] reg_din;

    logic [31:0]  prdata [3];
    logic [2:0]   pready;
    logic [2:0]   pslverr;
    logic [255:0] reg_dout [3];
    logic [7:0]   wr_pulse [3];
    logic [3:0]   rd_pulse [3];

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic [11:0] a;
        logic        w;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl [14];
    logic [255:0] mdl [3];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb4_regbank #(.WAIT(g == 0 ? 0 : g + 1)) u_dut (
            .clk(clk), .rstn(rstn), .PSEL(sel[g]), .PENABLE(PENABLE),
            .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
            .PPROT(PPROT), .PRDATA(prdata[g]), .PREADY(pready[g]),
            .PSLVERR(pslverr[g]), .reg_dout(reg_dout[g]), .reg_din(reg_din),
            .wr_pulse(wr_pulse[g]), .rd_pulse(rd_pulse[g])
        );
    end

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic xfer(input int d, input logic [11:0] a, input logic w,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [2:0] pr, input logic [31:0] er,
                        input logic ee, input string tag);
        exp_t e;
        int n;
        int ix;
        logic [7:0] wp;
        logic [3:0] rp;
        ix = int'(a[11:2]);
        wp = (w && !ee && ix < 8) ? 8'(1 << ix) : 8'h0;
        rp = (!w && !ee && ix >= 8 && ix < 12) ? 4'(1 << (ix - 8)) : 4'h0;
        exp_q.push_back('{err: ee, rdata: er});
        sel[d] = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w;
        PWDATA = wd; PSTRB = st; PPROT = pr;
        @(posedge clk); #1 PENABLE = 1'b1;
        n = 0;
        @(negedge clk);
        while (!pready[d] && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk({tag, ".wait"}, 256'(n), 256'(d == 0 ? 0 : d + 1));
        e = exp_q.pop_front();
        chk({tag, ".rdata"}, 256'(prdata[d]), 256'(e.rdata));
        chk({tag, ".err"}, 256'(pslverr[d]), 256'(e.err));
        if (w && !ee && ix < 8)
            for (int b = 0; b < 4; b++)
                if (st[b]) mdl[d][ix*32+b*8 +: 8] = wd[b*8 +: 8];
        @(posedge clk); #1;
        sel[d] = 1'b0; PENABLE = 1'b0;
        chk({tag, ".wr_pulse"}, 256'(wr_pulse[d]), 256'(wp));
        chk({tag, ".rd_pulse"}, 256'(rd_pulse[d]), 256'(rp));
        chk({tag, ".reg_dout"}, reg_dout[d], mdl[d]);
        @(posedge clk); #1;
        chk({tag, ".pulse_end"}, 256'({wr_pulse[d], rd_pulse[d]}), 256'(0));
    endtask

    initial begin
        reg_din = {32'hFFFF0000, 32'h0, 32'h12345678, 32'h0000CAFE};
        for (int i = 0; i < 3; i++) mdl[i] = '0;

        tbl[0]  = '{12'h004, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tbl[1]  = '{12'h004, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{12'h000, 1'b1, 32'h11223344, 4'hF, 32'h0,        1'b0};
        tbl[3]  = '{12'h000, 1'b1, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        tbl[4]  = '{12'h000, 1'b0, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        tbl[5]  = '{12'h01C, 1'b1, 32'h000000FF, 4'h0, 32'h0,        1'b0};
        tbl[6]  = '{12'h01C, 1'b0, 32'h0,        4'hF, 32'h0,        1'b0};
        tbl[7]  = '{12'h024, 1'b0, 32'h0,        4'hF, 32'h12345678, 1'b0};
        tbl[8]  = '{12'h020, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        tbl[9]  = '{12'h030, 1'b0, 32'h0,        4'hF, 32'h0,        1'b1};
        tbl[10] = '{12'h007, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        tbl[11] = '{12'h02C, 1'b0, 32'h0,        4'hF, 32'hFFFF0000, 1'b0};
        tbl[12] = '{12'h3FC, 1'b1, 32'h01234567, 4'hF, 32'h0,        1'b1};
        tbl[13] = '{12'h020, 1'b0, 32'h0,        4'hF, 32'h0000CAFE, 1'b0};

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d.ready", i), 256'(pready[i]), 256'(0));
            chk($sformatf("rst%0d.err", i), 256'(pslverr[i]), 256'(0));
            chk($sformatf("rst%0d.rdata", i), 256'(prdata[i]), 256'(0));
            chk($sformatf("rst%0d.dout", i), reg_dout[i], 256'(0));
            chk($sformatf("rst%0d.pulse", i),
                256'({wr_pulse[i], rd_pulse[i]}), 256'(0));
        end
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++)
            xfer(0, tbl[i].a, tbl[i].w, tbl[i].wd, tbl[i].st, 3'b001,
                 tbl[i].er, tbl[i].ee, $sformatf("vec%0d", i));

        xfer(2, 12'h020, 1'b0, 32'h0, 4'h0, 3'b001, 32'h0000CAFE, 1'b0, "w3_ro0");
        xfer(2, 12'h030, 1'b0, 32'h0, 4'h0, 3'b001, 32'h0, 1'b1, "w3_unmap");

        // Abort mid-ACCESS on the WAIT=2 instance
        xfer(1, 12'h008, 1'b1, 32'h00000011, 4'hF, 3'b001, 32'h0, 1'b0, "ab_pre");
        sel[1] = 1'b1; PENABLE = 1'b0; PADDR = 12'h008; PWRITE = 1'b1;
        PWDATA = 32'h99999999; PSTRB = 4'hF;
        @(posedge clk); #1 PENABLE = 1'b1;
        @(posedge clk); #1 sel[1] = 1'b0; PENABLE = 1'b0;
        @(posedge clk); #1;
        chk("ab.ready", 256'(pready[1]), 256'(0));
        chk("ab.pulse", 256'(wr_pulse[1]), 256'(0));
        chk("ab.dout", reg_dout[1], mdl[1]);
        xfer(1, 12'h008, 1'b0, 32'h0, 4'h0, 3'b001, 32'h00000011, 1'b0, "ab_post");

        // Privilege check on RW writes
`ifdef APB_REGBANK_PPROT_EN
        xfer(0, 12'h000, 1'b1, 32'h5, 4'hF, 3'b000, 32'h0, 1'b1, "prot_user");
`else
        xfer(0, 12'h000, 1'b1, 32'h5, 4'hF, 3'b000, 32'h0, 1'b0, "prot_user");
`endif
        xfer(0, 12'h000, 1'b1, 32'h5, 4'hF, 3'b001, 32'h0, 1'b0, "prot_priv");
        xfer(0, 12'h000, 1'b0, 32'h0, 4'h0, 3'b000, 32'h5, 1'b0, "prot_rd");

        // Reset asserted mid-write on the WAIT=2 instance
        sel[1] = 1'b1; PENABLE = 1'b0; PADDR = 12'h00C; PWRITE = 1'b1;
        PWDATA = 32'hAAAA5555; PSTRB = 4'hF; PPROT = 3'b001;
        @(posedge clk); #1 PENABLE = 1'b1;
        @(posedge clk); #1 rstn = 1'b0;
        for (int i = 0; i < 3; i++) mdl[i] = '0;
        @(posedge clk); #1;
        chk("rmw.ready", 256'(pready[1]), 256'(0));
        chk("rmw.dout", reg_dout[1], 256'(0));
        sel[1] = 1'b0; PENABLE = 1'b0; rstn = 1'b1;
        @(posedge clk); #1;
        chk("rmw.pulse", 256'(wr_pulse[1]), 256'(0));
        xfer(1, 12'h00C, 1'b0, 32'h0, 4'h0, 3'b001, 32'h0, 1'b0, "rmw_rd");
        xfer(1, 12'h00C, 1'b1, 32'h600DF00D, 4'hF, 3'b001, 32'h0, 1'b0, "rmw_wr");
        xfer(1, 12'h00C, 1'b0, 32'h0, 4'h0, 3'b001, 32'h600DF00D, 1'b0, "rmw_rd2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
